// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares one memory port between the fetch (IF) and data (MEM) stages.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_read,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic [1:0]  d_wmask,
  output logic [15:0] d_rdata,
  output logic        d_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp
);

  localparam int                 SW    = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0]      C_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2
  } state_t;

  state_t        r_state;
  logic [SW-1:0] r_streak;
  logic [15:0]   r_if_rdata;
  logic [15:0]   r_d_rdata;

  logic w_d_req;
  logic w_starve;

  assign w_d_req  = d_read | d_write;
  // A waiting fetch that has already let MAX_D_STREAK data grants pass wins next.
  assign w_starve = if_read && (r_streak == C_MAX);

  assign if_resp  = mem_resp && (r_state == ST_SERVE_I);
  assign d_resp   = mem_resp && (r_state == ST_SERVE_D);
  assign if_rdata = if_resp ? mem_rdata : r_if_rdata;
  assign d_rdata  = d_resp  ? mem_rdata : r_d_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_streak        <= '0;
      r_if_rdata      <= '0;
      r_d_rdata       <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_d_req && !w_starve) begin
            r_state         <= ST_SERVE_D;
            r_streak        <= !if_read ? '0 :
                               (r_streak == C_MAX) ? C_MAX : r_streak + SW'(1);
            mem_read        <= d_read;
            mem_write       <= d_write;
            mem_address     <= d_addr;
            mem_wdata       <= d_wdata;
            mem_byte_enable <= d_write ? d_wmask : 2'b11;
          end else if (if_read) begin
            r_state         <= ST_SERVE_I;
            r_streak        <= '0;
            mem_read        <= 1'b1;
            mem_write       <= 1'b0;
            mem_address     <= if_addr;
            mem_byte_enable <= 2'b11;
          end else begin
            r_streak        <= '0;
          end
        end
        ST_SERVE_I: begin
          if (mem_resp) begin
            r_state    <= ST_IDLE;
            r_if_rdata <= mem_rdata;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
          end
        end
        ST_SERVE_D: begin
          if (mem_resp) begin
            r_state   <= ST_IDLE;
            r_d_rdata <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Scoreboard bench for mem_port_arbiter with a latency-programmable memory model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_read;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_resp;
  logic        d_read, d_write;
  logic [15:0] d_addr, d_wdata;
  logic [1:0]  d_wmask;
  logic [15:0] d_rdata;
  logic        d_resp;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_rdata;
  logic        mem_resp;

  mem_port_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_read(if_read), .if_addr(if_addr), .if_rdata(if_rdata), .if_resp(if_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rdq[$];
  int          errors = 0;
  int          checks = 0;
  int          mem_lat = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Expected transaction in grant order; the memory model returns rdata in the same order.
  task automatic expect_tx(input bit is_d, input bit wr, input logic [15:0] a,
                           input logic [15:0] wd, input logic [1:0] be, input logic [15:0] rd);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = a; e.wdata = wd; e.be = be; e.rdata = rd;
    exp_q.push_back(e);
    rdq.push_back(rd);
  endtask

  task automatic d_req(input bit wr, input logic [15:0] a, input logic [15:0] wd,
                       input logic [1:0] m);
    int n;
    d_read = !wr; d_write = wr; d_addr = a; d_wdata = wd; d_wmask = m;
    n = 0;
    while (!d_resp && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("d_done", {31'b0, d_resp}, 32'd1);
    @(posedge clk); #1;
    d_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic i_req(input logic [15:0] a);
    int n;
    if_read = 1'b1; if_addr = a;
    n = 0;
    while (!if_resp && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("if_done", {31'b0, if_resp}, 32'd1);
    @(posedge clk); #1;
    if_read = 1'b0;
  endtask

  // Memory model: responds mem_lat cycles after the strobe first appears.
  initial begin : mem_model
    bit ab;
    mem_resp = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (rst_n && (mem_read || mem_write)) begin
        ab = 1'b0;
        for (int k = 1; k < mem_lat; k++) begin
          @(posedge clk); #1;
          if (!rst_n) begin
            ab = 1'b1;
            break;
          end
        end
        if (!ab) begin
          mem_rdata = (rdq.size() > 0) ? rdq.pop_front() : 16'hDEAD;
          mem_resp  = 1'b1;
          @(posedge clk); #1;
          mem_resp  = 1'b0;
        end
      end
    end
  end

  // Monitor: every completion is matched against the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && (if_resp || d_resp)) begin
      chk("single_resp", {31'b0, if_resp & d_resp}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got if_resp=%b d_resp=%b expected none", if_resp, d_resp);
      end else begin
        e = exp_q.pop_front();
        chk("resp_side", {31'b0, d_resp}, {31'b0, e.is_d});
        chk("mem_address", {16'b0, mem_address}, {16'b0, e.addr});
        chk("mem_op", {30'b0, mem_write, mem_read}, e.wr ? 32'd2 : 32'd1);
        chk("mem_byte_enable", {30'b0, mem_byte_enable}, {30'b0, e.be});
        if (e.wr) chk("mem_wdata", {16'b0, mem_wdata}, {16'b0, e.wdata});
        chk("rdata", {16'b0, (e.is_d ? d_rdata : if_rdata)}, {16'b0, e.rdata});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    rst_n = 1'b0;
    if_read = 1'b0; if_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_strobes", {30'b0, mem_write, mem_read}, 32'd0);
    chk("rst_mem_be", {30'b0, mem_byte_enable}, 32'd0);
    chk("rst_resps", {30'b0, if_resp, d_resp}, 32'd0);
    rst_n = 1'b1;

    // 1: reset in the middle of a store
    @(posedge clk); #1;
    mem_lat = 8;
    d_write = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1357; d_wmask = 2'b11;
    n = 0;
    while (!mem_write && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t1_write_seen", {31'b0, mem_write}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t1_strobes", {30'b0, mem_write, mem_read}, 32'd0);
    chk("t1_addr_data", {mem_address, mem_wdata}, 32'd0);
    chk("t1_be", {30'b0, mem_byte_enable}, 32'd0);
    chk("t1_resps", {30'b0, if_resp, d_resp}, 32'd0);
    d_write = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem_lat = 3;
    repeat (3) @(negedge clk);
    chk("t1_idle_after", {30'b0, mem_write, mem_read}, 32'd0);

    // 2: lone fetch, arbitration latency and rdata hold
    @(posedge clk); #1;
    expect_tx(1'b0, 1'b0, 16'h0040, 16'h0000, 2'b11, 16'h1234);
    fork
      i_req(16'h0040);
      begin
        @(negedge clk);
        chk("t2_no_read_cycle1", {31'b0, mem_read}, 32'd0);
        @(negedge clk);
        chk("t2_read_cycle2", {31'b0, mem_read}, 32'd1);
      end
    join
    @(negedge clk);
    chk("t2_if_rdata_hold", {16'b0, if_rdata}, 32'h1234);

    // 4: four data grants, then the starved fetch, then the remaining store
    @(posedge clk); #1;
    expect_tx(1'b1, 1'b1, 16'h0200, 16'hA000, 2'b11, 16'h0000);
    expect_tx(1'b1, 1'b1, 16'h0201, 16'hA001, 2'b10, 16'h0000);
    expect_tx(1'b1, 1'b1, 16'h0202, 16'hA002, 2'b01, 16'h0000);
    expect_tx(1'b1, 1'b1, 16'h0203, 16'hA003, 2'b11, 16'h0000);
    expect_tx(1'b0, 1'b0, 16'h0050, 16'h0000, 2'b11, 16'h1111);
    expect_tx(1'b1, 1'b1, 16'h0204, 16'hA004, 2'b10, 16'h0000);
    fork
      begin
        d_req(1'b1, 16'h0200, 16'hA000, 2'b11);
        d_req(1'b1, 16'h0201, 16'hA001, 2'b10);
        d_req(1'b1, 16'h0202, 16'hA002, 2'b01);
        d_req(1'b1, 16'h0203, 16'hA003, 2'b11);
        d_req(1'b1, 16'h0204, 16'hA004, 2'b10);
      end
      i_req(16'h0050);
    join

    // 3: simultaneous requests; data must win again, so the streak was cleared
    @(posedge clk); #1;
    expect_tx(1'b1, 1'b0, 16'h0100, 16'h0000, 2'b11, 16'h0F0F);
    expect_tx(1'b0, 1'b0, 16'h0044, 16'h0000, 2'b11, 16'h5678);
    fork
      d_req(1'b0, 16'h0100, 16'h0000, 2'b00);
      i_req(16'h0044);
    join
    @(negedge clk);
    chk("t3_d_rdata_hold", {16'b0, d_rdata}, 32'h0F0F);

    // 5: requester inputs change mid-access; bus keeps captured values
    @(posedge clk); #1;
    mem_lat = 5;
    expect_tx(1'b1, 1'b1, 16'h0300, 16'hBEEF, 2'b01, 16'h0000);
    fork
      d_req(1'b1, 16'h0300, 16'hBEEF, 2'b01);
      begin
        repeat (2) @(posedge clk);
        #2;
        d_addr = 16'h0BAD; d_wdata = 16'h0000; d_wmask = 2'b10;
        @(negedge clk);
        chk("t5_mid_addr", {16'b0, mem_address}, 32'h0300);
        chk("t5_mid_wdata", {16'b0, mem_wdata}, 32'hBEEF);
        chk("t5_mid_be", {30'b0, mem_byte_enable}, 32'd1);
      end
    join
    mem_lat = 3;

    // 6: spurious mem_resp while idle
    @(posedge clk); #1;
    mem_rdata = 16'h7777;
    mem_resp = 1'b1;
    @(negedge clk);
    chk("t6_no_resp", {30'b0, if_resp, d_resp}, 32'd0);
    @(posedge clk); #1;
    mem_resp = 1'b0;
    @(negedge clk);
    chk("t6_still_idle", {30'b0, mem_write, mem_read}, 32'd0);
    @(posedge clk); #1;
    expect_tx(1'b0, 1'b0, 16'h0060, 16'h0000, 2'b11, 16'hA5A5);
    i_req(16'h0060);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
